// File: rtl/line_mem_arbiter.sv
// Round-robin arbiter sharing one 128-bit line-memory port between the I-cache
// (refills) and the D-cache (refills and write-backs), with a memory-hang timeout.
module line_mem_arbiter #(
    parameter int TIMEOUT = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_req,
    input  logic [31:0]  i_addr,
    output logic         i_ready,
    output logic [127:0] i_data,
    input  logic         d_req,
    input  logic         d_we,
    input  logic [31:0]  d_addr,
    input  logic [127:0] d_wdata,
    output logic         d_ready,
    output logic [127:0] d_data,
    output logic         mem_req,
    output logic         mem_we,
    output logic [31:0]  mem_addr,
    output logic [127:0] mem_wdata,
    input  logic         mem_ack,
    input  logic [127:0] mem_rdata,
    output logic [1:0]   grant,
    output logic         bus_err,
    output logic [1:0]   fsm_state
);

    // Handshake: a requester holds req (and its payload) high until its ready
    // pulse, then must drop req for at least one cycle before the next request.
    typedef enum logic [1:0] {IDLE = 2'd0, I_XFER = 2'd1, D_XFER = 2'd2} state_t;

    localparam logic [7:0] TO = 8'(TIMEOUT);

    state_t     state;
    logic       i_blk, d_blk;
    logic       last;       // 0: I served last, 1: D served last
    logic [7:0] cnt;
    logic       i_elig, d_elig, tmo;
    logic       unused_addr_bits;

    assign i_elig           = i_req && !i_blk;
    assign d_elig           = d_req && !d_blk;
    assign tmo              = (TO != 8'd0) && (cnt == TO);
    assign fsm_state        = state;
    assign unused_addr_bits = ^{i_addr[3:0], d_addr[3:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            i_ready   <= 1'b0;
            d_ready   <= 1'b0;
            i_data    <= '0;
            d_data    <= '0;
            grant     <= 2'b00;
            bus_err   <= 1'b0;
            i_blk     <= 1'b0;
            d_blk     <= 1'b0;
            last      <= 1'b0;
            cnt       <= '0;
        end else begin
            i_ready <= 1'b0;
            d_ready <= 1'b0;
            // blk drops on the first low request; a completion below re-sets it.
            if (!i_req) i_blk <= 1'b0;
            if (!d_req) d_blk <= 1'b0;
            case (state)
                IDLE: begin
                    if (d_elig && (!i_elig || !last)) begin
                        state     <= D_XFER;
                        mem_req   <= 1'b1;
                        mem_we    <= d_we;
                        mem_addr  <= {d_addr[31:4], 4'b0000};
                        mem_wdata <= d_wdata;
                        grant     <= 2'b10;
                        cnt       <= '0;
                    end else if (i_elig) begin
                        state     <= I_XFER;
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b0;
                        mem_addr  <= {i_addr[31:4], 4'b0000};
                        mem_wdata <= d_wdata;
                        grant     <= 2'b01;
                        cnt       <= '0;
                    end
                end
                I_XFER, D_XFER: begin
                    if (mem_ack || tmo) begin
                        state   <= IDLE;
                        mem_req <= 1'b0;
                        grant   <= 2'b00;
                        if (!mem_ack) bus_err <= 1'b1;
                        if (state == I_XFER) begin
                            i_ready <= 1'b1;
                            i_blk   <= 1'b1;
                            last    <= 1'b0;
                            i_data  <= mem_ack ? mem_rdata : '0;
                        end else begin
                            d_ready <= 1'b1;
                            d_blk   <= 1'b1;
                            last    <= 1'b1;
                            if (!mem_we) d_data <= mem_ack ? mem_rdata : '0;
                        end
                    end else if (cnt != 8'hFF) begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_line_mem_arbiter.sv
// Scenario bench for line_mem_arbiter: refill, tie, write-back, late drop,
// timeout and reset mid-transfer, with queued expected line data.
module tb_line_mem_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic         i_req, d_req, d_we, mem_ack;
    logic [31:0]  i_addr, d_addr;
    logic [127:0] d_wdata, mem_rdata;
    logic         i_ready, d_ready, mem_req, mem_we, bus_err;
    logic [127:0] i_data, d_data, mem_wdata;
    logic [31:0]  mem_addr;
    logic [1:0]   grant, fsm_state;

    int errors = 0;
    int checks = 0;
    logic [127:0] exp_i_q[$];
    logic [127:0] exp_d_q[$];
    logic [127:0] d_model;
    logic [127:0] exp_v;

    line_mem_arbiter #(.TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_ready(i_ready), .i_data(i_data),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ready(d_ready), .d_data(d_data),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .grant(grant), .bus_err(bus_err), .fsm_state(fsm_state)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] rand_line();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic test_reset();
        rst = 1'b1; i_req = 0; d_req = 0; d_we = 0; mem_ack = 0;
        i_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0;
        tick(); tick();
        rst = 1'b0;
        d_model = '0;
        checks++; if ({mem_req, mem_we, i_ready, d_ready, bus_err, grant} !== 7'b0) begin errors++; $display("FAIL reset_ctrl: got %b exp 0", {mem_req, mem_we, i_ready, d_ready, bus_err, grant}); end
        checks++; if (mem_addr !== 32'h0 || mem_wdata !== 128'h0) begin errors++; $display("FAIL reset_mem_bus: got %h/%h exp 0", mem_addr, mem_wdata); end
        checks++; if (i_data !== 128'h0 || d_data !== 128'h0) begin errors++; $display("FAIL reset_data: got %h/%h exp 0", i_data, d_data); end
        checks++; if (fsm_state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d exp 0", fsm_state); end
    endtask

    task automatic test_i_refill();
        i_req = 1'b1; i_addr = 32'h0040_1238;
        tick();
        checks++; if (mem_req !== 1'b1 || grant !== 2'b01) begin errors++; $display("FAIL i_refill_grant: got req=%b grant=%b exp 1/01", mem_req, grant); end
        checks++; if (mem_addr !== 32'h0040_1230 || mem_we !== 1'b0) begin errors++; $display("FAIL i_refill_addr: got %h we=%b exp 00401230 we=0", mem_addr, mem_we); end
        tick(); tick();
        checks++; if (mem_req !== 1'b1 || i_ready !== 1'b0) begin errors++; $display("FAIL i_refill_hold: got req=%b rdy=%b exp 1/0", mem_req, i_ready); end
        mem_ack = 1'b1; mem_rdata = 128'hAAAAAAAA_AAAAAAAA_AAAAAAAA_AAAA0001;
        exp_i_q.push_back(128'hAAAAAAAA_AAAAAAAA_AAAAAAAA_AAAA0001);
        tick();
        mem_ack = 1'b0; i_req = 1'b0;
        checks++; if (i_ready !== 1'b1 || mem_req !== 1'b0 || grant !== 2'b00) begin errors++; $display("FAIL i_refill_done: got rdy=%b req=%b grant=%b exp 1/0/00", i_ready, mem_req, grant); end
        exp_v = exp_i_q.pop_front();
        checks++; if (i_data !== exp_v) begin errors++; $display("FAIL i_refill_data: got %h exp %h", i_data, exp_v); end
        tick();
        checks++; if (i_ready !== 1'b0 || i_data !== exp_v) begin errors++; $display("FAIL i_refill_pulse: got rdy=%b data=%h exp 0/%h", i_ready, i_data, exp_v); end
    endtask

    task automatic test_tie();
        logic [127:0] rd;
        logic [31:0]  ia;
        rst = 1'b1; tick(); rst = 1'b0; d_model = '0;
        ia = $urandom;
        i_req = 1'b1; i_addr = ia; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_1000;
        tick();
        checks++; if (grant !== 2'b10 || mem_addr !== 32'h0000_1000) begin errors++; $display("FAIL tie_first: got grant=%b addr=%h exp 10/00001000", grant, mem_addr); end
        rd = rand_line();
        mem_ack = 1'b1; mem_rdata = rd; exp_d_q.push_back(rd); d_model = rd;
        tick();
        mem_ack = 1'b0; d_req = 1'b0;
        checks++; if (d_ready !== 1'b1 || i_ready !== 1'b0 || grant !== 2'b00 || mem_req !== 1'b0) begin errors++; $display("FAIL tie_idle: got d=%b i=%b grant=%b req=%b exp 1/0/00/0", d_ready, i_ready, grant, mem_req); end
        exp_v = exp_d_q.pop_front();
        checks++; if (d_data !== exp_v) begin errors++; $display("FAIL tie_d_data: got %h exp %h", d_data, exp_v); end
        tick();
        checks++; if (grant !== 2'b01 || mem_req !== 1'b1 || mem_addr !== {ia[31:4], 4'b0}) begin errors++; $display("FAIL tie_second: got grant=%b req=%b addr=%h exp 01/1/%h", grant, mem_req, mem_addr, {ia[31:4], 4'b0}); end
        rd = rand_line();
        mem_ack = 1'b1; mem_rdata = rd; exp_i_q.push_back(rd);
        tick();
        mem_ack = 1'b0; i_req = 1'b0;
        exp_v = exp_i_q.pop_front();
        checks++; if (i_ready !== 1'b1 || i_data !== exp_v) begin errors++; $display("FAIL tie_i_done: got rdy=%b data=%h exp 1/%h", i_ready, i_data, exp_v); end
        tick();
    endtask

    task automatic test_write_back();
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0000_2004; d_wdata = {4{32'h5555_5555}};
        tick();
        checks++; if (grant !== 2'b10 || mem_we !== 1'b1 || mem_addr !== 32'h0000_2000) begin errors++; $display("FAIL wb_bus: got grant=%b we=%b addr=%h exp 10/1/00002000", grant, mem_we, mem_addr); end
        checks++; if (mem_wdata !== {4{32'h5555_5555}}) begin errors++; $display("FAIL wb_wdata: got %h exp 5555...", mem_wdata); end
        mem_ack = 1'b1; mem_rdata = rand_line(); exp_d_q.push_back(d_model);
        d_wdata = rand_line();
        tick();
        mem_ack = 1'b0; d_req = 1'b0; d_we = 1'b0;
        exp_v = exp_d_q.pop_front();
        checks++; if (d_ready !== 1'b1 || d_data !== exp_v) begin errors++; $display("FAIL wb_done: got rdy=%b data=%h exp 1/%h", d_ready, d_data, exp_v); end
        tick();
    endtask

    task automatic test_late_drop();
        logic [127:0] rd;
        i_req = 1'b1; i_addr = 32'h0000_3348;
        tick();
        checks++; if (grant !== 2'b01) begin errors++; $display("FAIL late_i_grant: got %b exp 01", grant); end
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_3000;
        rd = rand_line(); mem_ack = 1'b1; mem_rdata = rd; exp_i_q.push_back(rd);
        tick();
        mem_ack = 1'b0;
        exp_v = exp_i_q.pop_front();
        checks++; if (i_ready !== 1'b1 || i_data !== exp_v) begin errors++; $display("FAIL late_i_done: got rdy=%b data=%h exp 1/%h", i_ready, i_data, exp_v); end
        tick();
        checks++; if (grant !== 2'b10 || mem_addr !== 32'h0000_3000) begin errors++; $display("FAIL late_d_grant: got grant=%b addr=%h exp 10/00003000", grant, mem_addr); end
        i_req = 1'b0;
        rd = rand_line(); mem_ack = 1'b1; mem_rdata = rd; exp_d_q.push_back(rd); d_model = rd;
        tick();
        mem_ack = 1'b0; d_req = 1'b0;
        exp_v = exp_d_q.pop_front();
        checks++; if (d_ready !== 1'b1 || d_data !== exp_v) begin errors++; $display("FAIL late_d_done: got rdy=%b data=%h exp 1/%h", d_ready, d_data, exp_v); end
        tick();
        // I alone holds its request past ready: it must not be re-served.
        i_req = 1'b1; i_addr = 32'h0000_4400;
        tick();
        rd = rand_line(); mem_ack = 1'b1; mem_rdata = rd; exp_i_q.push_back(rd);
        tick();
        mem_ack = 1'b0;
        exp_v = exp_i_q.pop_front();
        checks++; if (i_ready !== 1'b1 || i_data !== exp_v) begin errors++; $display("FAIL late_b_done: got rdy=%b data=%h exp 1/%h", i_ready, i_data, exp_v); end
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++; if (grant !== 2'b00 || mem_req !== 1'b0) begin errors++; $display("FAIL late_blocked_%0d: got grant=%b req=%b exp 00/0", c, grant, mem_req); end
        end
        i_req = 1'b0;
        tick();
        i_req = 1'b1;
        tick();
        checks++; if (grant !== 2'b01 || mem_addr !== 32'h0000_4400) begin errors++; $display("FAIL late_regrant: got grant=%b addr=%h exp 01/00004400", grant, mem_addr); end
        mem_ack = 1'b1; mem_rdata = rand_line(); exp_i_q.push_back(mem_rdata);
        tick();
        mem_ack = 1'b0; i_req = 1'b0;
        exp_v = exp_i_q.pop_front();
        checks++; if (i_data !== exp_v) begin errors++; $display("FAIL late_regrant_data: got %h exp %h", i_data, exp_v); end
        tick();
    endtask

    task automatic test_timeout();
        int n;
        i_req = 1'b1; i_addr = 32'h0000_5008;
        exp_i_q.push_back(128'h0);
        tick();
        n = mem_req ? 1 : 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (mem_req) n++;
            else break;
        end
        checks++; if (n != 5) begin errors++; $display("FAIL timeout_len: got %0d exp 5", n); end
        checks++; if (i_ready !== 1'b1 || bus_err !== 1'b1) begin errors++; $display("FAIL timeout_flag: got rdy=%b err=%b exp 1/1", i_ready, bus_err); end
        exp_v = exp_i_q.pop_front();
        checks++; if (i_data !== exp_v) begin errors++; $display("FAIL timeout_data: got %h exp %h", i_data, exp_v); end
        i_req = 1'b0;
        tick(); tick();
        checks++; if (bus_err !== 1'b1 || i_ready !== 1'b0) begin errors++; $display("FAIL timeout_sticky: got err=%b rdy=%b exp 1/0", bus_err, i_ready); end
    endtask

    task automatic test_reset_mid_xfer();
        logic [127:0] rd;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_6000;
        tick();
        checks++; if (grant !== 2'b10) begin errors++; $display("FAIL rmx_grant: got %b exp 10", grant); end
        tick();
        rst = 1'b1; d_req = 1'b0;
        tick();
        rst = 1'b0; d_model = '0;
        checks++; if ({mem_req, d_ready, bus_err, grant} !== 5'b0) begin errors++; $display("FAIL rmx_ctrl: got %b exp 0", {mem_req, d_ready, bus_err, grant}); end
        checks++; if (mem_addr !== 32'h0 || i_data !== 128'h0 || d_data !== 128'h0) begin errors++; $display("FAIL rmx_regs: got %h/%h/%h exp 0", mem_addr, i_data, d_data); end
        mem_ack = 1'b1; mem_rdata = rand_line();
        tick();
        mem_ack = 1'b0;
        checks++; if (d_ready !== 1'b0 || mem_req !== 1'b0 || fsm_state !== 2'd0) begin errors++; $display("FAIL rmx_stray_ack: got rdy=%b req=%b st=%0d exp 0/0/0", d_ready, mem_req, fsm_state); end
        d_req = 1'b1; d_addr = 32'h0000_701C;
        tick();
        checks++; if (grant !== 2'b10 || mem_addr !== 32'h0000_7010) begin errors++; $display("FAIL rmx_new_grant: got grant=%b addr=%h exp 10/00007010", grant, mem_addr); end
        rd = rand_line(); mem_ack = 1'b1; mem_rdata = rd; exp_d_q.push_back(rd);
        tick();
        mem_ack = 1'b0; d_req = 1'b0;
        exp_v = exp_d_q.pop_front();
        checks++; if (d_ready !== 1'b1 || d_data !== exp_v) begin errors++; $display("FAIL rmx_new_done: got rdy=%b data=%h exp 1/%h", d_ready, d_data, exp_v); end
        tick();
    endtask

    initial begin
        test_reset();
        test_i_refill();
        test_tie();
        test_write_back();
        test_late_drop();
        test_timeout();
        test_reset_mid_xfer();
        checks++; if (exp_i_q.size() != 0 || exp_d_q.size() != 0) begin errors++; $display("FAIL queues_drained: got %0d/%0d exp 0/0", exp_i_q.size(), exp_d_q.size()); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/line_mem_arbiter.md
# line_mem_arbiter

Two-requester arbiter sharing the single 128-bit line-memory port between the instruction cache (line refills, read-only) and the data cache (line refills and write-backs). It sits between both caches' miss paths and the memory controller. It sequences one line transaction at a time and arbitrates round-robin. It enforces a request-drop rule so a requester that samples its ready one cycle late is not re-served, and it converts memory-side hangs into a flagged error.

## Interface
- TIMEOUT, 64, cycles `mem_req` may stay high without `mem_ack` before the transfer is aborted; legal range 0–255; 0 disables the timeout.

- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- i_req  in  1  I-cache line read request; held high with stable `i_addr` until `i_ready` is seen
- i_addr  in  32  I-cache request byte address
- i_ready  out  1  one-cycle pulse: I transaction complete
- i_data  out  128  I line data; valid with `i_ready`, held until the next I completion
- d_req  in  1  D-cache request; held with stable `d_we`, `d_addr`, `d_wdata` until `d_ready`
- d_we  in  1  1 = line write-back, 0 = line read
- d_addr  in  32  D-cache request byte address
- d_wdata  in  128  write-back line
- d_ready  out  1  one-cycle pulse: D transaction complete
- d_data  out  128  D read line; valid with `d_ready` on reads, unchanged on writes
- mem_req  out  1  memory transaction active
- mem_we  out  1  write when high
- mem_addr  out  32  line-aligned address, {addr[31:4], 4'b0}
- mem_wdata  out  128  write line
- mem_ack  in  1  memory completion; read data valid on `mem_rdata` in the same cycle
- mem_rdata  in  128  memory read line
- grant  out  2  one-hot owner, {D, I}; 2'b00 when idle
- bus_err  out  1  sticky timeout flag, cleared only by `rst`

## Operation
- States: IDLE, I_XFER, D_XFER. All outputs are registered.
- Eligibility:
  - I is eligible when `i_req` is high and `i_blk` is low. D is eligible likewise with `d_blk`.
  - `x_blk` is set when requester x completes. It clears on the first cycle `x_req` is sampled low.
  - A requester must deassert its request for at least one cycle between transactions.
- IDLE, one eligible requester: grant it and move to that requester's XFER state.
- IDLE, both eligible: grant the requester not served last. The `last` bit resets to I, so the first tie goes to D.
- On entering XFER:
  - `mem_req` = 1.
  - `mem_addr` is latched from the requester's address with the low 4 bits zeroed.
  - `mem_we` is latched from `d_we` for D and forced to 0 for I.
  - `mem_wdata` is latched from `d_wdata`.
  - `grant` is set and the timeout counter is cleared.
- XFER with `mem_ack` = 1:
  - Next edge: `mem_req` = 0, `grant` = 0, state returns to IDLE.
  - The owner's ready pulses for one cycle. Its data register loads `mem_rdata`, except for D writes.
  - `last` is updated and the owner's `blk` bit is set.
- XFER with `mem_ack` = 0:
  - The counter increments, saturating at 8 bits.
  - When TIMEOUT≠0 and the counter equals TIMEOUT, the transfer aborts at the next edge. This behaves as a completion except that the data register loads 0 (reads) and `bus_err` is set to 1.
- Request changes during XFER are ignored; latched values drive memory.
- A request dropped mid-XFER does not cancel the transfer. Completion still pulses ready and sets `blk`, which clears on the next low cycle.
- `mem_ack` while `mem_req` = 0 is ignored.

## Timing
- Reset values: state IDLE; `mem_req`, `mem_we`, `i_ready`, `d_ready`, `bus_err`, `blk` bits all 0; `grant` 2'b00; `mem_addr`, `mem_wdata`, `i_data`, `d_data` all 0; `last` = I; counter 0.
- Request sampled at edge n in IDLE: `mem_req` is high from n+1.
- `mem_ack` sampled at edge k: ready and data are valid in cycle k+1, and `mem_req` is low in k+1.
- Minimum request-to-ready latency is 2 cycles, with `mem_ack` in the first `mem_req` cycle.
- The earliest next grant is edge k+1, so `mem_req` is high again in k+2. There is always at least one idle `mem_req`=0 cycle between transfers.
- Timeout: `mem_req` stays high for exactly TIMEOUT+1 cycles, then ready pulses with `bus_err` rising in the same cycle.
- Reset mid-XFER drops `mem_req` on the next cycle. No ready pulse is generated.

## Test plan
- I refill: `i_req`=1 with `i_addr`=0x0040_1238; memory acks after 3 cycles with 0xAAAA…_0001 -> `mem_addr`=0x0040_1230, `mem_we`=0, one `i_ready` pulse, `i_data`=0xAAAA…_0001, `grant` 01 then 00.
- Tie after reset: `i_req` and `d_req` (read, 0x1000) rise the same cycle -> D served first; `i_ready` only after a second `mem_req` phase with one idle cycle between; `grant` sequence 10, 00, 01.
- Write-back: `d_we`=1, `d_addr`=0x2004, `d_wdata`=0x55…55 -> `mem_we`=1, `mem_addr`=0x2000, `mem_wdata`=0x55…55; `d_ready` pulses; `d_data` unchanged.
- Late drop: I holds `i_req` high 2 cycles after `i_ready` -> no second I grant until `i_req` is seen low; meanwhile a pending `d_req` is granted immediately.
- Timeout: TIMEOUT=4, `mem_ack` never asserted -> `mem_req` high 5 cycles, then `i_ready`=1 with `i_data`=0 and `bus_err`=1; `bus_err` stays 1 until `rst`.
- Reset mid-XFER: `rst` during D_XFER, then a stray `mem_ack` -> no `d_ready`; all outputs at reset values; a new request is served normally.
